mc_cu: RTL and testbench
========================

MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath/PC/counter width.
REQ-002 SHALL have parameter RST_PC, default 64'h8000_0000, meaning PC value after reset.
REQ-003 SHALL have parameter MEM_TO, default 255, meaning max wait cycles for a handshake ack before trap.
REQ-004 SHALL have parameter TW, default 8, meaning timeout counter width; MEM_TO < 2**TW.
REQ-005 SHALL have port clk  in  1  system clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low (single clock domain, polarity and synchronicity fixed).
REQ-007 SHALL have port ifu_req  out  1  fetch request, held until ifu_ack.
REQ-008 SHALL have port ifu_ack  in  1  fetch done; instruction valid this cycle.
REQ-009 SHALL have port ir_load  out  1  one-cycle pulse latching instruction into IR.
REQ-010 SHALL have ports dec_jump, dec_jumpr, dec_branch, dec_regwr, dec_memrd, dec_memwr, dec_ebreak, dec_illegal  in  1 each  decoded control from IDU.
REQ-011 SHALL have ports alu_out, tgt_b, tgt_j  in  XLEN  ALU result, absolute branch target, absolute jal target.
REQ-012 SHALL have ports lsu_req, lsu_we  out  1  data-memory request and write-enable, held until lsu_ack.
REQ-013 SHALL have port lsu_ack  in  1  data-memory access complete.
REQ-014 SHALL have port pc  out  XLEN  current PC register.
REQ-015 SHALL have port wen_regs  out  1  register-file write strobe.
REQ-016 SHALL have ports halt, trap  out  1  sticky stop indicators.
REQ-017 SHALL have port retired  out  XLEN  retired-instruction counter.
REQ-018 SHALL have port state  out  3  FSM state encoding, for debug.

Function
REQ-019 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6; all outputs registered or decoded from state only.
REQ-020 FETCH: ifu_req=1; on ifu_ack=1 at clock edge, pulse ir_load next cycle and enter DECODE; ack with ifu_req=0 ignored.
REQ-021 DECODE (1 cycle): dec_ebreak -> HALT; else dec_illegal -> TRAP; else EXEC; ebreak wins if both set.
REQ-022 EXEC (1 cycle): enter MEM if dec_memrd|dec_memwr, else WB.
REQ-023 MEM: lsu_req=1, lsu_we=dec_memwr; on lsu_ack enter WB; dec_memrd and dec_memwr both set -> TRAP from EXEC.
REQ-024 Timeout counter (TW bits) SHALL clear on entering FETCH/MEM, increment each waiting cycle; reaching MEM_TO without ack -> TRAP; ack on the MEM_TO cycle wins.
REQ-025 WB (1 cycle): wen_regs=dec_regwr; retired increments by 1, wrapping from all-ones to 0; next state FETCH.
REQ-026 PC update at WB exit: dec_jumpr -> alu_out with bit0 cleared; else dec_jump -> tgt_j; else dec_branch and alu_out==1 -> tgt_b; else pc+4 (mod 2**XLEN).
REQ-027 Next-PC bit1 set (misaligned) SHALL enter TRAP instead of FETCH, PC unchanged, no retire, wen_regs still asserted for the faulting jal/jalr.
REQ-028 HALT, TRAP absorbing until reset; ifu_req, lsu_req, wen_regs, ir_load all 0 there.
REQ-029 dec_* and operand inputs sampled only in DECODE..WB; IDU holds them stable from DECODE to WB exit.

Reset
REQ-030 rst_n=0 SHALL immediately force state=FETCH, pc=RST_PC, retired=0, timeout=0, halt=trap=ir_load=wen_regs=lsu_req=0; ifu_req=1 after release.
REQ-031 Reset mid-handshake SHALL drop lsu_req/ifu_req without waiting for ack; acks arriving during reset ignored.

Verification
REQ-032 ALU instr, ifu_ack after 3 cycles, dec_regwr=1 -> FETCH(4)->DECODE->EXEC->WB, wen_regs one pulse, pc=RST_PC+4, retired=1.
REQ-033 Branch, alu_out=1, tgt_b=0x8000_0100 -> pc=0x8000_0100; repeat alu_out=0 -> pc+4.
REQ-034 jalr alu_out=0x8000_0203 -> pc=0x8000_0202... bit1 set -> TRAP, pc held; alu_out=0x8000_0201 -> pc=0x8000_0200.
REQ-035 Load, lsu_ack never arrives -> TRAP exactly MEM_TO cycles after MEM entry; ack on cycle MEM_TO -> WB.
REQ-036 dec_ebreak in DECODE -> HALT, outputs quiet 20 cycles; rst_n pulse low in MEM -> FETCH, pc=RST_PC, lsu_req=0 immediately.
REQ-037 retired preset via 2**XLEN-1 retires (XLEN=8 build) -> wraps to 0.

Source files
------------

// File: rtl/mc_cu_if.sv
// Fetch and data-memory handshake bundle between the multi-cycle control unit
// and its instruction-fetch / load-store units.
interface mc_cu_if;
    // Handshake: a request is raised by the control unit and held high until the
    // matching ack is sampled high on a rising clock edge; the access completes on
    // that edge. An ack seen while its request is low is ignored.
    logic ifu_req;
    logic ifu_ack;
    logic ir_load;
    logic lsu_req;
    logic lsu_we;
    logic lsu_ack;

    modport master (
        output ifu_req,
        output ir_load,
        output lsu_req,
        output lsu_we,
        input  ifu_ack,
        input  lsu_ack
    );

    modport slave (
        input  ifu_req,
        input  ir_load,
        input  lsu_req,
        input  lsu_we,
        output ifu_ack,
        output lsu_ack
    );
endinterface

// File: rtl/mc_cu.sv
// Multi-cycle RISC-V style control unit: sequences fetch, decode, execute,
// memory and write-back, owns the PC and retired counter, and traps on faults.
module mc_cu #(
    parameter int              XLEN   = 64,
    parameter logic [XLEN-1:0] RST_PC = 64'h8000_0000,
    parameter int              MEM_TO = 255,
    parameter int              TW     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_cu_if.master         bus,
    input  logic            dec_jump,
    input  logic            dec_jumpr,
    input  logic            dec_branch,
    input  logic            dec_regwr,
    input  logic            dec_memrd,
    input  logic            dec_memwr,
    input  logic            dec_ebreak,
    input  logic            dec_illegal,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] tgt_b,
    input  logic [XLEN-1:0] tgt_j,
    output logic [XLEN-1:0] pc,
    output logic            wen_regs,
    output logic            halt,
    output logic            trap,
    output logic [XLEN-1:0] retired,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] retired_q, retired_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [XLEN-1:0] npc;
    logic            tmo_hit;

    // The wait about to end is the MEM_TO-th one; an ack on it still wins.
    assign tmo_hit = (tmo_q == TW'(MEM_TO - 1));

    always_comb begin
        npc = pc_q + XLEN'(4);
        if (dec_jumpr) begin
            npc = {alu_out[XLEN-1:1], 1'b0};
        end else if (dec_jump) begin
            npc = tgt_j;
        end else if (dec_branch && (alu_out == XLEN'(1))) begin
            npc = tgt_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RST_PC;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_FETCH: begin
                if (bus.ifu_ack) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DECODE: begin
                if (dec_ebreak) begin
                    state_d = S_HALT;
                end else if (dec_illegal) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_memrd && dec_memwr) begin
                    state_d = S_TRAP;
                end else if (dec_memrd || dec_memwr) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.lsu_ack) begin
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WB: begin
                // A misaligned target faults before commit: PC and retired stay put.
                if (npc[1]) begin
                    state_d = S_TRAP;
                end else begin
                    state_d   = S_FETCH;
                    pc_d      = npc;
                    retired_d = retired_q + XLEN'(1);
                    tmo_d     = '0;
                end
            end
            S_HALT: state_d = S_HALT;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Requests are gated by rst_n so an in-flight handshake drops the moment reset asserts.
    assign bus.ifu_req = rst_n && (state_q == S_FETCH);
    assign bus.lsu_req = rst_n && (state_q == S_MEM);
    assign bus.lsu_we  = (state_q == S_MEM) && dec_memwr;
    assign bus.ir_load = (state_q == S_DECODE);
    assign wen_regs    = (state_q == S_WB) && dec_regwr;
    assign halt        = (state_q == S_HALT);
    assign trap        = (state_q == S_TRAP);
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// Directed bench for mc_cu: a 64-bit instance for sequencing, PC, timeout and
// reset behaviour, and an 8-bit instance for retired-counter wrap.
module tb_mc_cu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int          MEM_TO = 255;

    localparam logic [7:0] F_JUMP    = 8'h80;
    localparam logic [7:0] F_JUMPR   = 8'h40;
    localparam logic [7:0] F_BRANCH  = 8'h20;
    localparam logic [7:0] F_REGWR   = 8'h10;
    localparam logic [7:0] F_MEMRD   = 8'h08;
    localparam logic [7:0] F_MEMWR   = 8'h04;
    localparam logic [7:0] F_EBREAK  = 8'h02;
    localparam logic [7:0] F_ILLEGAL = 8'h01;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst8_n = 1'b0;

    initial begin
        forever #5 clk = ~clk;
    end

    // ---------------- 64-bit DUT ----------------
    mc_cu_if bus ();
    logic        dec_jump, dec_jumpr, dec_branch, dec_regwr;
    logic        dec_memrd, dec_memwr, dec_ebreak, dec_illegal;
    logic [63:0] alu_out, tgt_b, tgt_j;
    logic [63:0] pc, retired;
    logic        wen_regs, halt, trap;
    logic [2:0]  state;

    mc_cu #(.XLEN(64), .RST_PC(RST_PC), .MEM_TO(MEM_TO), .TW(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .dec_jump(dec_jump), .dec_jumpr(dec_jumpr), .dec_branch(dec_branch),
        .dec_regwr(dec_regwr), .dec_memrd(dec_memrd), .dec_memwr(dec_memwr),
        .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
        .alu_out(alu_out), .tgt_b(tgt_b), .tgt_j(tgt_j),
        .pc(pc), .wen_regs(wen_regs), .halt(halt), .trap(trap),
        .retired(retired), .state(state)
    );

    // ---------------- 8-bit DUT (counter wrap) ----------------
    mc_cu_if bus8 ();
    logic [7:0] zero8;
    logic [7:0] pc8, retired8;
    logic       wen8, halt8, trap8;
    logic [2:0] state8;

    assign zero8        = 8'h00;
    assign bus8.ifu_ack = bus8.ifu_req;
    assign bus8.lsu_ack = 1'b0;

    mc_cu #(.XLEN(8), .RST_PC(8'h80), .MEM_TO(15), .TW(4)) dut8 (
        .clk(clk), .rst_n(rst8_n), .bus(bus8),
        .dec_jump(1'b0), .dec_jumpr(1'b0), .dec_branch(1'b0),
        .dec_regwr(1'b1), .dec_memrd(1'b0), .dec_memwr(1'b0),
        .dec_ebreak(1'b0), .dec_illegal(1'b0),
        .alu_out(zero8), .tgt_b(zero8), .tgt_j(zero8),
        .pc(pc8), .wen_regs(wen8), .halt(halt8), .trap(trap8),
        .retired(retired8), .state(state8)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_ret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_pc(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, pc, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_dec(input logic [7:0] f, input logic [63:0] alu,
                           input logic [63:0] tb_v, input logic [63:0] tj_v);
        {dec_jump, dec_jumpr, dec_branch, dec_regwr,
         dec_memrd, dec_memwr, dec_ebreak, dec_illegal} = f;
        alu_out = alu;
        tgt_b   = tb_v;
        tgt_j   = tj_v;
    endtask

    // Called at a negedge; returns at the negedge right after reset release.
    task automatic do_reset();
        bus.ifu_ack = 1'b0;
        bus.lsu_ack = 1'b0;
        set_dec(8'h00, 64'd0, 64'd0, 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 64'd0;
        exp_q.delete();
    endtask

    // Called at a negedge in FETCH; ack is withheld for n cycles.
    task automatic fetch(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.ifu_ack = 1'b0;
            @(negedge clk);
        end
        bus.ifu_ack = 1'b1;
        @(negedge clk);
        bus.ifu_ack = 1'b0;
        check({tag, "_decode_state"}, state, 3'd1);
        check({tag, "_ir_load"}, bus.ir_load, 1'b1);
    endtask

    task automatic run_alu(input int n, input logic exp_wen, input string tag);
        fetch(n, tag);
        @(negedge clk);
        check({tag, "_exec_state"}, state, 3'd2);
        @(negedge clk);
        check({tag, "_wb_state"}, state, 3'd4);
        check({tag, "_wen_regs"}, wen_regs, exp_wen);
        @(negedge clk);
        exp_ret++;
        check({tag, "_fetch_state"}, state, 3'd0);
        check({tag, "_wen_after"}, wen_regs, 1'b0);
        check_pc({tag, "_pc"});
        check({tag, "_retired"}, retired, exp_ret);
    endtask

    // Load or store, ack raised after ack_wait idle MEM cycles.
    task automatic run_mem(input logic we, input int ack_wait, input string tag);
        fetch(0, tag);
        @(negedge clk);
        check({tag, "_exec_state"}, state, 3'd2);
        @(negedge clk);
        check({tag, "_mem_state"}, state, 3'd3);
        check({tag, "_lsu_req"}, bus.lsu_req, 1'b1);
        check({tag, "_lsu_we"}, bus.lsu_we, we);
        for (int i = 0; i < ack_wait; i++) @(negedge clk);
        check({tag, "_mem_still"}, state, 3'd3);
        bus.lsu_ack = 1'b1;
        @(negedge clk);
        bus.lsu_ack = 1'b0;
        check({tag, "_wb_state"}, state, 3'd4);
        @(negedge clk);
        exp_ret++;
        check({tag, "_fetch_state"}, state, 3'd0);
        check_pc({tag, "_pc"});
        check({tag, "_retired"}, retired, exp_ret);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.ifu_ack = 1'b0;
        bus.lsu_ack = 1'b0;
        exp_ret     = 64'd0;
        set_dec(8'h00, 64'd0, 64'd0, 64'd0);

        // Reset values while rst_n is low
        @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_retired", retired, 64'd0);
        check("rst_halt_trap", {halt, trap}, 2'b00);
        check("rst_quiet", {bus.ir_load, wen_regs, bus.lsu_req, bus.ifu_req}, 4'b0000);
        rst_n = 1'b1;
        #1;
        check("rel_ifu_req", bus.ifu_req, 1'b1);
        @(negedge clk);

        // ALU op, ack after 3 wait cycles
        set_dec(F_REGWR, 64'd5, 64'd0, 64'd0);
        exp_q.push_back(64'h8000_0004);
        run_alu(3, 1'b1, "alu");

        // Branch taken then not taken
        set_dec(F_BRANCH, 64'd1, 64'h8000_0100, 64'd0);
        exp_q.push_back(64'h8000_0100);
        run_alu(0, 1'b0, "br_taken");
        set_dec(F_BRANCH, 64'd0, 64'h8000_0100, 64'd0);
        exp_q.push_back(64'h8000_0104);
        run_alu(1, 1'b0, "br_not");

        // jal and aligned jalr (bit0 cleared)
        set_dec(F_JUMP | F_REGWR, 64'd0, 64'd0, 64'h8000_0400);
        exp_q.push_back(64'h8000_0400);
        run_alu(2, 1'b1, "jal");
        set_dec(F_JUMPR | F_REGWR, 64'h8000_0201, 64'd0, 64'h8000_0400);
        exp_q.push_back(64'h8000_0200);
        run_alu(0, 1'b1, "jalr");

        // Load acked on the last allowed MEM cycle, then a store
        set_dec(F_MEMRD | F_REGWR, 64'd0, 64'd0, 64'd0);
        exp_q.push_back(64'h8000_0204);
        run_mem(1'b0, MEM_TO - 1, "ld_late");
        set_dec(F_MEMWR, 64'd0, 64'd0, 64'd0);
        exp_q.push_back(64'h8000_0208);
        run_mem(1'b1, 2, "st");

        // Misaligned jalr target traps with PC held
        set_dec(F_JUMPR | F_REGWR, 64'h8000_0203, 64'd0, 64'd0);
        fetch(0, "jalr_mis");
        @(negedge clk);
        @(negedge clk);
        check("jalr_mis_wb", state, 3'd4);
        check("jalr_mis_wen", wen_regs, 1'b1);
        @(negedge clk);
        check("jalr_mis_trap_state", state, 3'd6);
        check("jalr_mis_trap_flag", {halt, trap}, 2'b01);
        check("jalr_mis_pc", pc, 64'h8000_0208);
        check("jalr_mis_retired", retired, exp_ret);
        repeat (5) @(negedge clk);
        check("trap_sticky", state, 3'd6);
        check("trap_quiet", {bus.ir_load, wen_regs, bus.lsu_req, bus.ifu_req}, 4'b0000);

        // Load whose ack never arrives
        do_reset();
        check("ld_to_rst_pc", pc, RST_PC);
        set_dec(F_MEMRD | F_REGWR, 64'd0, 64'd0, 64'd0);
        fetch(0, "ld_to");
        @(negedge clk);
        @(negedge clk);
        check("ld_to_mem_entry", state, 3'd3);
        for (int i = 0; i < MEM_TO - 1; i++) @(negedge clk);
        check("ld_to_last_wait", state, 3'd3);
        @(negedge clk);
        check("ld_to_trap", state, 3'd6);
        check("ld_to_retired", retired, 64'd0);

        // Fetch whose ack never arrives
        do_reset();
        for (int i = 0; i < MEM_TO - 1; i++) @(negedge clk);
        check("if_to_last_wait", state, 3'd0);
        @(negedge clk);
        check("if_to_trap", state, 3'd6);
        check("if_to_ifu_req", bus.ifu_req, 1'b0);

        // ebreak wins over illegal; HALT stays quiet
        do_reset();
        set_dec(F_EBREAK | F_ILLEGAL | F_REGWR, 64'd0, 64'd0, 64'd0);
        fetch(1, "ebreak");
        @(negedge clk);
        check("ebreak_halt", state, 3'd5);
        for (int i = 0; i < 20; i++) begin
            bus.ifu_ack = 1'b1;
            bus.lsu_ack = 1'b1;
            @(negedge clk);
            check("halt_quiet", {bus.ir_load, wen_regs, bus.lsu_req, bus.ifu_req, halt, trap},
                  6'b000010);
        end
        check("halt_pc", pc, RST_PC);

        // Illegal alone traps
        do_reset();
        set_dec(F_ILLEGAL, 64'd0, 64'd0, 64'd0);
        fetch(0, "illegal");
        @(negedge clk);
        check("illegal_trap", state, 3'd6);

        // Read and write both set traps from EXEC
        do_reset();
        set_dec(F_MEMRD | F_MEMWR, 64'd0, 64'd0, 64'd0);
        fetch(0, "rdwr");
        @(negedge clk);
        check("rdwr_exec", state, 3'd2);
        @(negedge clk);
        check("rdwr_trap", state, 3'd6);
        check("rdwr_lsu_req", bus.lsu_req, 1'b0);

        // Reset pulse in the middle of a load
        do_reset();
        set_dec(F_REGWR, 64'd0, 64'd0, 64'd0);
        exp_q.push_back(64'h8000_0004);
        run_alu(0, 1'b1, "pre_rst");
        set_dec(F_MEMRD | F_REGWR, 64'd0, 64'd0, 64'd0);
        fetch(0, "mid_rst");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_in_mem", bus.lsu_req, 1'b1);
        rst_n       = 1'b0;
        bus.lsu_ack = 1'b1;
        bus.ifu_ack = 1'b1;
        #1;
        check("mid_rst_lsu_req", bus.lsu_req, 1'b0);
        check("mid_rst_state", state, 3'd0);
        check("mid_rst_pc", pc, RST_PC);
        check("mid_rst_retired", retired, 64'd0);
        @(negedge clk);
        bus.lsu_ack = 1'b0;
        bus.ifu_ack = 1'b0;
        rst_n       = 1'b1;
        #1;
        check("mid_rst_rel_ifu_req", bus.ifu_req, 1'b1);
        @(negedge clk);
        check("mid_rst_rel_state", state, 3'd0);

        // 8-bit build: retired wraps after 256 retires
        begin
            int wb_n;
            wb_n   = 0;
            rst8_n = 1'b1;
            for (int c = 0; c < 3000 && wb_n < 255; c++) begin
                @(negedge clk);
                if (state8 == 3'd4) wb_n++;
            end
            check("w8_wb_count", wb_n, 255);
            @(negedge clk);
            check("w8_retired_ff", retired8, 8'hFF);
            check("w8_pc_ff", pc8, 8'h7C);
            for (int c = 0; c < 10 && state8 != 3'd4; c++) @(negedge clk);
            check("w8_wen", wen8, 1'b1);
            @(negedge clk);
            check("w8_retired_wrap", retired8, 8'h00);
            check("w8_pc_wrap", pc8, 8'h80);
            check("w8_flags", {halt8, trap8}, 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
